pipe_skid_stage: RTL and testbench

Parametrised pipeline-stage register. It replaces the fixed per-boundary stage registers (IF/ID, ID/EX, EX/MEM) with one reusable block. It carries a DATA_W-bit packed control/data bundle with valid/ready flow control and a two-entry skid buffer, so upstream `in_ready` never depends combinationally on downstream `out_ready`. A flush loads a programmable bubble pattern and can selectively retain fields such as the PC.

---
 rtl/pipe_skid_stage.sv | 94 +++++++++
 tb/tb_pipe_skid_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Reusable pipeline-stage register with valid/ready handshake and a two-entry skid buffer.
// A flush loads a bubble pattern into the main register and can keep selected fields, such as the PC.
module pipe_skid_stage #(
  parameter int                 DATA_W     = 32,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = 32'h0000_0013,
  parameter logic [DATA_W-1:0]  KEEP_MASK  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = main_q;

  // Handshake outputs are registered alongside the state, so in_ready never sees out_ready or flush combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_q    <= BUBBLE_VAL;
      skid_q    <= BUBBLE_VAL;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= 2'd0;
    end else if (flush) begin
      state     <= EMPTY;
      main_q    <= (main_q & KEEP_MASK) | (BUBBLE_VAL & ~KEEP_MASK);
      skid_q    <= BUBBLE_VAL;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state     <= ONE;
            main_q    <= in_data;
            out_valid <= 1'b1;
            occupancy <= 2'd1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            state     <= FULL;
            skid_q    <= in_data;
            in_ready  <= 1'b0;
            occupancy <= 2'd2;
          end else if (out_fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state     <= ONE;
            main_q    <= skid_q;
            in_ready  <= 1'b1;
            occupancy <= 2'd1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          occupancy <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: directed scenarios followed by randomized traffic.
// The reference is a two-deep FIFO model plus the last value that left the main register.
module tb_pipe_skid_stage;

  localparam logic [31:0] BUB  = 32'h0000_0013;
  localparam logic [31:0] KEEP = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  logic [31:0] last_main = BUB;

  pipe_skid_stage #(
    .DATA_W     (32),
    .BUBBLE_VAL (32'h13),
    .KEEP_MASK  (32'hFFFF_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever the DUT presents a bundle, its value must be the oldest one the model holds.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got out_valid=1 data=%h expected no entry at %0t", out_data, $time);
      end else begin
        chk("out_data", out_data, sb[0]);
        if (out_ready) last_main = sb.pop_front();
      end
    end
  end

  // Called just after a rising edge: checks status against the model, drives one cycle, advances the model.
  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f, output logic acc);
    int          cnt;
    logic [31:0] fmain;
    cnt = sb.size();
    chk("out_valid", {31'd0, out_valid}, {31'd0, cnt > 0});
    chk("in_ready",  {31'd0, in_ready},  {31'd0, cnt < 2});
    chk("occupancy", {30'd0, occupancy}, cnt);
    if (cnt == 0) chk("idle_data", out_data, last_main);
    fmain     = (cnt > 0) ? sb[0] : last_main;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    acc = v && (cnt < 2) && !f;
    if (acc) sb.push_back(d);
    @(posedge clk);
    #1;
    if (f) begin
      sb.delete();
      last_main = (fmain & KEEP) | (BUB & ~KEEP);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 10 && sb.size() != 0; i++) drive(1'b0, 32'd0, 1'b1, 1'b0, a);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", sb.size());
    end
  endtask

  initial begin
    logic        a;
    logic        pend;
    logic [31:0] pd;
    int          tries;

    // Reset with no clock edge in between.
    #1 rst = 1'b1;
    #1;
    chk("rst_data",  out_data, BUB);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_occ",   {30'd0, occupancy}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    // Streaming one bundle per cycle.
    for (int i = 1; i <= 4; i++) drive(1'b1, i, 1'b1, 1'b0, a);
    drain();

    // Stall fill: third bundle waits upstream until downstream frees space.
    drive(1'b1, 32'hA, 1'b0, 1'b0, a);
    drive(1'b1, 32'hB, 1'b0, 1'b0, a);
    drive(1'b1, 32'hC, 1'b0, 1'b0, a);
    chk("stall_c_held", {31'd0, a}, 32'd0);
    tries = 0;
    do begin
      drive(1'b1, 32'hC, 1'b1, 1'b0, a);
      tries++;
    end while (!a && tries < 5);
    chk("stall_c_accepted", {31'd0, a}, 32'd1);
    drain();

    // Flush keeps the upper half of the main register.
    drive(1'b1, 32'hABCD_1234, 1'b0, 1'b0, a);
    drive(1'b0, 32'd0, 1'b0, 1'b1, a);
    chk("flush_keep", out_data, 32'hABCD_0013);
    drive(1'b0, 32'd0, 1'b0, 1'b0, a);

    // Flush while full with an incoming bundle: all three are discarded.
    drive(1'b1, 32'h1111_0001, 1'b0, 1'b0, a);
    drive(1'b1, 32'h2222_0002, 1'b0, 1'b0, a);
    drive(1'b1, 32'h3333_0003, 1'b1, 1'b1, a);
    drive(1'b1, 32'h4444_0004, 1'b1, 1'b0, a);
    drain();

    // Asynchronous reset while full, between clock edges.
    drive(1'b1, 32'h5555_0005, 1'b0, 1'b0, a);
    drive(1'b1, 32'h6666_0006, 1'b0, 1'b0, a);
    #2 rst = 1'b1;
    #1;
    chk("arst_data",  out_data, BUB);
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_occ",   {30'd0, occupancy}, 32'd0);
    sb.delete();
    last_main = BUB;
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    // Randomized traffic; an offered bundle is held until accepted or flushed.
    pend = 1'b0;
    pd   = '0;
    for (int i = 0; i < 600; i++) begin
      logic v, r, f;
      if (!pend) begin
        v  = $urandom_range(0, 2) != 0;
        pd = $urandom;
      end else begin
        v = 1'b1;
      end
      r = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      f = $urandom_range(0, 39) == 0;
      drive(v, pd, r, f, a);
      pend = v && !a && !f;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1);
  end

endmodule
